// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: converts a binary result to BCD using a sequential
// double-dabble engine (one bit per clock). It then time-multiplexes the
// committed digits onto a single 4-bit bcd bus with a one-hot digit enable.
//
// Input handshake: value_in is taken on a rising edge only when value_valid=1
// and busy=0. A strobe seen while busy=1, including the COMMIT cycle, is
// dropped with no queuing. conv_done pulses for one cycle when the new digits
// are committed.
module display_scan_ctrl #(
    parameter int DATA_W      = 14,
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_LZ    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     value_in,
    input  logic                  value_valid,
    output logic                  busy,
    output logic                  conv_done,
    output logic [3:0]            bcd,
    output logic [NUM_DIGITS-1:0] digit_en
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int SR_W  = BCD_W + DATA_W;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int REF_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    // Largest value that fits in the display: 10^NUM_DIGITS - 1.
    function automatic int unsigned max_display(input int n);
        int unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p - 1;
    endfunction

    localparam int unsigned MAX_VAL = max_display(NUM_DIGITS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [SR_W-1:0]   sr_q;
    logic [SR_W-1:0]   sr_adj;
    logic [CNT_W-1:0]  cnt_q;
    logic              ovf_q;
    logic [BCD_W-1:0]  digit_q;
    logic [BCD_W-1:0]  commit_digits;
    logic              seen_nz;
    logic [REF_W-1:0]  ref_q;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  idx_d1;
    logic              en_vld_q;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and status outputs; the cycle count never depends on ovf
    always_comb begin
        state_d   = state_q;
        busy      = 1'b0;
        conv_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (value_valid) state_d = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = COMMIT;
            end
            COMMIT: begin
                busy      = 1'b1;
                conv_done = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Add 3 to every BCD nibble >= 5 before the next left shift
    always_comb begin
        sr_adj = sr_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sr_q[DATA_W + 4*i +: 4] >= 4'd5)
                sr_adj[DATA_W + 4*i +: 4] = sr_q[DATA_W + 4*i +: 4] + 4'd3;
        end
    end

    // Digits to commit: blank on overflow, else optionally blank leading zeros
    always_comb begin
        commit_digits = sr_q[SR_W-1:DATA_W];
        seen_nz       = 1'b0;
        if (ovf_q) begin
            commit_digits = {NUM_DIGITS{4'hF}};
        end else if (BLANK_LZ != 0) begin
            // Digit 0 is never blanked, so a value of 0 still shows "0".
            for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
                if (sr_q[DATA_W + 4*i +: 4] != 4'd0) seen_nz = 1'b1;
                if (!seen_nz) commit_digits[4*i +: 4] = 4'hF;
            end
        end
    end

    // Conversion datapath: load, shift DATA_W times, then commit the digits
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q    <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            digit_q <= {NUM_DIGITS{4'hF}};
        end else begin
            case (state_q)
                IDLE: begin
                    if (value_valid) begin
                        sr_q  <= {{BCD_W{1'b0}}, value_in};
                        cnt_q <= CNT_W'(DATA_W);
                        ovf_q <= ({{(32-DATA_W){1'b0}}, value_in} > MAX_VAL);
                    end
                end
                SHIFT: begin
                    sr_q  <= sr_adj << 1;
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                COMMIT: begin
                    digit_q <= commit_digits;
                end
                default: ;
            endcase
        end
    end

    // Free-running scan: bcd follows the index, and digit_en lags one cycle to
    // line up with the downstream registered segment decoder
    always_ff @(posedge clk) begin
        if (rst) begin
            ref_q    <= '0;
            idx_q    <= '0;
            idx_d1   <= '0;
            en_vld_q <= 1'b0;
            bcd      <= 4'hF;
            digit_en <= '0;
        end else begin
            if (ref_q == REF_W'(REFRESH_DIV - 1)) begin
                ref_q <= '0;
                idx_q <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
            end else begin
                ref_q <= ref_q + REF_W'(1);
            end
            bcd      <= digit_q[{idx_q, 2'b00} +: 4];
            idx_d1   <= idx_q;
            en_vld_q <= 1'b1;
            digit_en <= en_vld_q ? (NUM_DIGITS'(1) << idx_d1) : '0;
        end
    end

endmodule
